// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: turns RV32 byte/half/word accesses into word-aligned Memory
// reads/writes. Optional build macro MISALIGN_TRAP_EN traps misaligned accesses instead of splitting.
module mem_access_unit #(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              illegal,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_func3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef MISALIGN_TRAP_EN
    ,
    output logic              misalign
`endif
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD0  = 3'd1;
    localparam logic [2:0] S_RD1  = 3'd2;
    localparam logic [2:0] S_WR0  = 3'd3;
    localparam logic [2:0] S_WR1  = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state;
    logic              op_read;
    logic [2:0]        op_func3;
    logic [1:0]        op_off;
    logic [31:0]       op_wdata;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    logic              cross_q;
    logic              illegal_q;
    logic              trap_q;
    logic [31:0]       word0;
    logic [31:0]       word1;

    logic              accept;
    logic              req_h;
    logic              req_w;
    logic              req_legal;
    logic              req_cross;
    logic              req_trap;
    logic [ADDR_W-1:0] req_lo;

    always_comb begin
        accept    = req_valid && (req_read || req_write);
        req_h     = (req_func3[1:0] == 2'b01);
        req_w     = (req_func3[1:0] == 2'b10);
        req_legal = req_read ? (req_func3 != 3'b011 && req_func3[2:1] != 2'b11)
                             : (req_func3[2] == 1'b0 && req_func3[1:0] != 2'b11);
        req_cross = (req_h && req_addr[1:0] == 2'b11) || (req_w && req_addr[1:0] != 2'b00);
        req_lo    = {req_addr[ADDR_W-1:2], 2'b00};
        req_trap  = !req_legal;
`ifdef MISALIGN_TRAP_EN
        req_trap  = !req_legal || (req_h && req_addr[0]) || (req_w && req_addr[1:0] != 2'b00);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_read   <= 1'b0;
            op_func3  <= 3'b000;
            op_off    <= 2'b00;
            op_wdata  <= 32'h0;
            lo_addr   <= '0;
            hi_addr   <= '0;
            cross_q   <= 1'b0;
            illegal_q <= 1'b0;
            trap_q    <= 1'b0;
            word0     <= 32'h0;
            word1     <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_read   <= req_read;
                        op_func3  <= req_func3;
                        op_off    <= req_addr[1:0];
                        op_wdata  <= req_wdata;
                        lo_addr   <= req_lo;
                        hi_addr   <= req_lo + ADDR_W'(4);
                        cross_q   <= req_cross;
                        illegal_q <= !req_legal;
                        trap_q    <= req_trap;
                        word0     <= 32'h0;
                        word1     <= 32'h0;
                        if (req_trap)
                            state <= S_DONE;
                        else if (req_read)
                            state <= S_RD0;
                        else if (req_w && !req_cross)
                            state <= S_WR0;
                        else
                            state <= S_RD0;
                    end
                end
                S_RD0: begin
                    word0 <= mem_rdata;
                    state <= cross_q ? S_RD1 : (op_read ? S_DONE : S_WR0);
                end
                S_RD1: begin
                    word1 <= mem_rdata;
                    state <= op_read ? S_DONE : S_WR0;
                end
                S_WR0:   state <= cross_q ? S_WR1 : S_DONE;
                S_WR1:   state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Store merge and load extraction both work on the two-word window {word1, word0}.
    logic [3:0]  size_mask;
    logic [7:0]  byte_en;
    logic [63:0] old64;
    logic [63:0] data64;
    logic [63:0] merged;
    logic [31:0] ld_word;
    logic [31:0] ld_ext;

    always_comb begin
        case (op_func3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        byte_en = {4'b0000, size_mask} << op_off;
        old64   = {word1, word0};
        data64  = {32'h0, op_wdata} << {op_off, 3'b000};
        for (int i = 0; i < 8; i++)
            merged[8*i +: 8] = byte_en[i] ? data64[8*i +: 8] : old64[8*i +: 8];
        ld_word = 32'(old64 >> {op_off, 3'b000});
        case (op_func3)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b010:  ld_ext = ld_word;
            3'b100:  ld_ext = {24'h0, ld_word[7:0]};
            3'b101:  ld_ext = {16'h0, ld_word[15:0]};
            default: ld_ext = 32'h0;
        endcase
    end

    // Strobes are masked by rst so a reset mid-sequence issues no further Memory access.
    always_comb begin
        stall      = (state != S_IDLE && state != S_DONE) || (state == S_IDLE && accept);
        resp_valid = (state == S_DONE);
        illegal    = (state == S_DONE) && illegal_q;
        mem_func3  = 3'b010;
        mem_read   = (state == S_RD0 || state == S_RD1) && !rst;
        mem_write  = (state == S_WR0 || state == S_WR1) && !rst;
        rdata      = (state == S_DONE && op_read && !trap_q) ? ld_ext : 32'h0;
        mem_addr   = '0;
        mem_wdata  = 32'h0;
        case (state)
            S_RD0:   mem_addr = lo_addr;
            S_RD1:   mem_addr = hi_addr;
            S_WR0: begin
                mem_addr  = lo_addr;
                mem_wdata = merged[31:0];
            end
            S_WR1: begin
                mem_addr  = hi_addr;
                mem_wdata = merged[63:32];
            end
            default: ;
        endcase
`ifdef MISALIGN_TRAP_EN
        misalign   = (state == S_DONE) && trap_q && !illegal_q;
`endif
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table over a modelled word Memory plus
// hand-written sequences for strobe ordering and reset in the middle of a split store.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write;
    logic [2:0]  req_func3;
    logic [10:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall, resp_valid, illegal, mem_read, mem_write;
    logic [31:0] rdata, mem_wdata, mem_rdata;
    logic [2:0]  mem_func3;
    logic [10:0] mem_addr;

    mem_access_unit #(.ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_read(req_read), .req_write(req_write),
        .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata), .stall(stall),
        .resp_valid(resp_valid), .rdata(rdata), .illegal(illegal), .mem_read(mem_read),
        .mem_write(mem_write), .mem_func3(mem_func3), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:511];
    assign mem_rdata = mem_read ? mem[mem_addr[10:2]] : 32'h0;
    always @(posedge clk)
        if (mem_write) mem[mem_addr[10:2]] <= mem_wdata;

    localparam logic [31:0] M0 = 32'h11223344;
    localparam logic [31:0] M1 = 32'h55667788;
    localparam logic [31:0] M7 = 32'hA1B2C3D4;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [10:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_illegal;
        int          exp_lat;
        int          exp_reads;
        int          exp_writes;
        logic [31:0] exp_m0;
        logic [31:0] exp_m1;
        logic [31:0] exp_m7;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    int          lat, n_reads, n_writes, n_both, n_stall, log_n;
    logic        acc_stall, res_illegal, after_resp, after_stall;
    logic [31:0] res_rdata;
    logic [10:0] log_addr [0:7];
    logic        log_wr   [0:7];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic rd, input logic wr, input logic [2:0] f3, input logic [10:0] addr,
                          input logic [31:0] wd, input logic [31:0] er, input logic ei, input int lt,
                          input int rds, input int wrs, input logic [31:0] m0, input logic [31:0] m1,
                          input logic [31:0] m7);
        vec_t v;
        v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wd;
        v.exp_rdata = er; v.exp_illegal = ei; v.exp_lat = lt;
        v.exp_reads = rds; v.exp_writes = wrs;
        v.exp_m0 = m0; v.exp_m1 = m1; v.exp_m7 = m7;
        vecs.push_back(v);
    endtask

    task automatic preload();
        for (int i = 0; i < 512; i++) mem[i] = 32'h0;
        mem[0]   = M0;
        mem[1]   = M1;
        mem[511] = M7;
    endtask

    // One request from acceptance to resp_valid, recording latency, strobes and results.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [10:0] addr, input logic [31:0] wd);
        logic got_resp;
        @(negedge clk);
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_func3 = f3; req_addr = addr; req_wdata = wd;
        #1 acc_stall = stall;
        lat = 0; n_reads = 0; n_writes = 0; n_both = 0; n_stall = 0; log_n = 0;
        got_resp = 1'b0; res_rdata = 32'hx; res_illegal = 1'bx;
        while (!got_resp && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (mem_read && mem_write) n_both++;
            if (stall) n_stall++;
            if ((mem_read || mem_write) && log_n < 8) begin
                log_addr[log_n] = mem_addr;
                log_wr[log_n]   = mem_write;
                log_n++;
            end
            if (mem_read)  n_reads++;
            if (mem_write) n_writes++;
            if (resp_valid) begin
                got_resp    = 1'b1;
                res_rdata   = rdata;
                res_illegal = illegal;
            end
        end
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        @(negedge clk);
        after_resp  = resp_valid;
        after_stall = stall;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_func3 = 3'b000; req_addr = 11'h0; req_wdata = 32'h0;
        preload();

        //     rd wr f3      addr    wdata         rdata         ill lat rd wr  m0            m1            m7
        addVec(1, 0, 3'b010, 11'h000, 32'h0,        32'h11223344, 0, 2, 1, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b001, 11'h003, 32'h0,        32'hFFFF8811, 0, 3, 2, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b101, 11'h003, 32'h0,        32'h00008811, 0, 3, 2, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b000, 11'h004, 32'h0,        32'hFFFFFF88, 0, 2, 1, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b100, 11'h007, 32'h0,        32'h00000055, 0, 2, 1, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b001, 11'h7FC, 32'h0,        32'hFFFFC3D4, 0, 2, 1, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b101, 11'h006, 32'h0,        32'h00005566, 0, 2, 1, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b001, 11'h001, 32'h0,        32'h00002233, 0, 2, 1, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b010, 11'h7FE, 32'h0,        32'h3344A1B2, 0, 3, 2, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b010, 11'h001, 32'h0,        32'h88112233, 0, 3, 2, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b011, 11'h000, 32'h0,        32'h00000000, 1, 1, 0, 0, M0,           M1,           M7);
        addVec(1, 0, 3'b110, 11'h004, 32'h0,        32'h00000000, 1, 1, 0, 0, M0,           M1,           M7);
        addVec(0, 1, 3'b100, 11'h004, 32'h12345678, 32'h00000000, 1, 1, 0, 0, M0,           M1,           M7);
        addVec(0, 1, 3'b010, 11'h004, 32'hDEADBEEF, 32'h00000000, 0, 2, 0, 1, M0,           32'hDEADBEEF, M7);
        addVec(0, 1, 3'b001, 11'h002, 32'h1234ABCD, 32'h00000000, 0, 3, 1, 1, 32'hABCD3344, M1,           M7);
        addVec(0, 1, 3'b000, 11'h005, 32'h000000EF, 32'h00000000, 0, 3, 1, 1, M0,           32'h5566EF88, M7);
        addVec(0, 1, 3'b000, 11'h7FF, 32'hFFFFFF55, 32'h00000000, 0, 3, 1, 1, M0,           M1,           32'h55B2C3D4);
        addVec(0, 1, 3'b001, 11'h003, 32'h0000BEEF, 32'h00000000, 0, 5, 2, 2, 32'hEF223344, 32'h556677BE, M7);
        addVec(0, 1, 3'b010, 11'h7FE, 32'hAABBCCDD, 32'h00000000, 0, 5, 2, 2, 32'h1122AABB, M1,           32'hCCDDC3D4);
        addVec(0, 1, 3'b010, 11'h002, 32'hAABBCCDD, 32'h00000000, 0, 5, 2, 2, 32'hCCDD3344, 32'h5566AABB, M7);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset stall",      32'(stall),      32'h0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("reset illegal",    32'(illegal),    32'h0);
        checkOutput("reset mem_read",   32'(mem_read),   32'h0);
        checkOutput("reset mem_write",  32'(mem_write),  32'h0);
        checkOutput("reset rdata",      rdata,           32'h0);
        checkOutput("reset mem_addr",   32'(mem_addr),   32'h0);
        checkOutput("reset mem_wdata",  mem_wdata,       32'h0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            preload();
            applyStimulus(vecs[i].rd, vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            checkOutput($sformatf("v%0d latency", i),     32'(lat),         32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d accept stall", i), 32'(acc_stall),  32'h1);
            checkOutput($sformatf("v%0d stall cycles", i), 32'(n_stall),    32'(vecs[i].exp_lat - 1));
            checkOutput($sformatf("v%0d rdata", i),       res_rdata,        vecs[i].exp_rdata);
            checkOutput($sformatf("v%0d illegal", i),     32'(res_illegal), 32'(vecs[i].exp_illegal));
            checkOutput($sformatf("v%0d reads", i),       32'(n_reads),     32'(vecs[i].exp_reads));
            checkOutput($sformatf("v%0d writes", i),      32'(n_writes),    32'(vecs[i].exp_writes));
            checkOutput($sformatf("v%0d rd+wr overlap", i), 32'(n_both),    32'h0);
            checkOutput($sformatf("v%0d resp pulse", i),  32'(after_resp),  32'h0);
            checkOutput($sformatf("v%0d idle stall", i),  32'(after_stall), 32'h0);
            checkOutput($sformatf("v%0d mem[000]", i),    mem[0],           vecs[i].exp_m0);
            checkOutput($sformatf("v%0d mem[004]", i),    mem[1],           vecs[i].exp_m1);
            checkOutput($sformatf("v%0d mem[7FC]", i),    mem[511],         vecs[i].exp_m7);
        end

        // Split store ordering: read lo, read hi, write lo, write hi.
        preload();
        applyStimulus(1'b0, 1'b1, 3'b010, 11'h002, 32'hAABBCCDD);
        checkOutput("sw002 strobe count", 32'(log_n), 32'd4);
        checkOutput("sw002 s0", {log_wr[0], 20'h0, log_addr[0]}, {1'b0, 20'h0, 11'h000});
        checkOutput("sw002 s1", {log_wr[1], 20'h0, log_addr[1]}, {1'b0, 20'h0, 11'h004});
        checkOutput("sw002 s2", {log_wr[2], 20'h0, log_addr[2]}, {1'b1, 20'h0, 11'h000});
        checkOutput("sw002 s3", {log_wr[3], 20'h0, log_addr[3]}, {1'b1, 20'h0, 11'h004});

        // Wrapping load: hi word address wraps to 0.
        preload();
        applyStimulus(1'b1, 1'b0, 3'b010, 11'h7FE, 32'h0);
        checkOutput("lw7FE strobe count", 32'(log_n), 32'd2);
        checkOutput("lw7FE addr0", 32'(log_addr[0]), 32'h7FC);
        checkOutput("lw7FE addr1", 32'(log_addr[1]), 32'h000);

        // Byte store touches only the word holding the byte.
        preload();
        applyStimulus(1'b0, 1'b1, 3'b000, 11'h005, 32'h000000EF);
        checkOutput("sb005 read addr",  32'(log_addr[0]), 32'h004);
        checkOutput("sb005 write addr", {log_wr[1], 20'h0, log_addr[1]}, {1'b1, 20'h0, 11'h004});

        // Reset while in WR1 of a split sw: lo word written, hi word never written.
        preload();
        @(negedge clk);
        req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1;
        req_func3 = 3'b010; req_addr = 11'h002; req_wdata = 32'hAABBCCDD;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        checkOutput("rstseq wr1 strobe", 32'(mem_write), 32'h1);
        checkOutput("rstseq wr1 addr",   32'(mem_addr),  32'h004);
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rstseq stall",      32'(stall),      32'h0);
        checkOutput("rstseq resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rstseq mem_write",  32'(mem_write),  32'h0);
        checkOutput("rstseq mem_addr",   32'(mem_addr),   32'h0);
        checkOutput("rstseq mem[000]",   mem[0],          32'hCCDD3344);
        checkOutput("rstseq mem[004]",   mem[1],          M1);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 3'b010, 11'h000, 32'h0);
        checkOutput("rstseq reload rdata", res_rdata,   32'hCCDD3344);
        checkOutput("rstseq reload lat",   32'(lat),    32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
